// File: rtl/instr_issue_if.sv
// Instruction issue bus: host-side push handshake, run enable, pipeline-side issue outputs, statistics.
// Latency: none, this is wiring only.
// Backpressure: in_ready from the issuer throttles in_valid from the host.
// Ports (signals): in_valid/in_instr/in_ready push channel, run issue enable,
//   instr_out/issue_valid to the pipeline, empty, issue_cnt/bubble_cnt statistics.
interface instr_issue_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             run;
    logic [31:0]      instr_out;
    logic             issue_valid;
    logic             empty;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    // Host side: drives words and the run enable, observes everything else.
    modport master (
        output in_valid, in_instr, run,
        input  in_ready, instr_out, issue_valid, empty, issue_cnt, bubble_cnt
    );

    // Issuer side.
    modport slave (
        input  in_valid, in_instr, run,
        output in_ready, instr_out, issue_valid, empty, issue_cnt, bubble_cnt
    );
endinterface

// File: rtl/instr_issue.sv
// Instruction FIFO plus RAW hazard check feeding a 3-stage non-forwarding ALU pipeline; inserts NOP bubbles.
// Latency: a hazard-free FIFO head appears on instr_out one cycle later; a pushed word is issuable the next cycle.
// Backpressure: in_ready = count < FIFO_DEPTH (a pop in the same cycle does not free a slot for a push).
// Ports: clk, rst (synchronous, active high), bus (instr_issue_if.slave): push channel, run, instr_out,
//   issue_valid, empty, saturating issue_cnt / bubble_cnt.
module instr_issue #(
    parameter int FIFO_DEPTH = 16,
    parameter int HAZ_WIN    = 3,
    parameter int CNT_W      = 16
) (
    input logic          clk,
    input logic          rst,
    instr_issue_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    // A producer issued HAZ_WIN slots ago has written back by the time the
    // current decision reaches the pipeline, so only the HAZ_WIN-1 newest
    // issue slots can still conflict. Keep at least one entry so the
    // arrays stay legal when HAZ_WIN is 1.
    localparam int SB_D = (HAZ_WIN > 1) ? HAZ_WIN - 1 : 1;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [31:0]      head;
    logic [5:0]       head_op;
    logic [4:0]       head_rs;
    logic [4:0]       head_rt;
    logic             fifo_empty;
    logic             fifo_ready;
    logic             push;
    logic             pop;
    logic             bubble;
    logic             hazard;

    logic [SB_D-1:0]  sb_we;
    logic [4:0]       sb_wsel [SB_D];

    logic [31:0]      instr_q;
    logic             valid_q;
    logic [CNT_W-1:0] issue_q;
    logic [CNT_W-1:0] bubble_q;

    assign fifo_empty = (count == '0);
    assign fifo_ready = (count < (AW+1)'(FIFO_DEPTH));
    assign push       = bus.in_valid && fifo_ready;

    assign head    = mem[rd_ptr];
    assign head_op = head[31:26];
    assign head_rs = head[20:16];
    assign head_rt = head[15:11];

    // With opcode[3] set, bits [15:11] belong to the immediate and are not a register read.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_D; i++) begin
            if ((HAZ_WIN > 1) && sb_we[i] &&
                ((sb_wsel[i] == head_rs) || (!head_op[3] && (sb_wsel[i] == head_rt)))) begin
                hazard = 1'b1;
            end
        end
        if (head_op == 6'd0) begin
            hazard = 1'b0;
        end
    end

    assign pop    = bus.run && !fifo_empty && !hazard;
    assign bubble = bus.run && !fifo_empty && hazard;

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            instr_q  <= 32'h0;
            valid_q  <= 1'b0;
            issue_q  <= '0;
            bubble_q <= '0;
            sb_we    <= '0;
            for (int i = 0; i < SB_D; i++) begin
                sb_wsel[i] <= 5'd0;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            instr_q <= pop ? head : 32'h0;
            valid_q <= pop;

            if (pop && (issue_q != '1)) begin
                issue_q <= issue_q + 1'b1;
            end
            if (bubble && (bubble_q != '1)) begin
                bubble_q <= bubble_q + 1'b1;
            end

            // Every slot shifts, bubbles and idle NOPs included, so the
            // window measures issue slots rather than issued instructions.
            for (int i = SB_D - 1; i > 0; i--) begin
                sb_we[i]   <= sb_we[i-1];
                sb_wsel[i] <= sb_wsel[i-1];
            end
            sb_we[0]   <= pop && (head_op != 6'd0);
            sb_wsel[0] <= head[25:21];
        end
    end

    assign bus.in_ready    = fifo_ready;
    assign bus.empty       = fifo_empty;
    assign bus.instr_out   = instr_q;
    assign bus.issue_valid = valid_q;
    assign bus.issue_cnt   = issue_q;
    assign bus.bubble_cnt  = bubble_q;
endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: directed scenarios plus random traffic against a slot-based reference model.
// Latency: expected state for each clock edge is queued right after the edge and checked on the next falling edge.
// Backpressure: pushes are held by the driver until the model reports acceptance.
module tb_instr_issue;
    localparam int DEPTH = 16;
    localparam int HW    = 3;
    localparam int CW    = 6;
    localparam int MAXC  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_issue_if #(.CNT_W(CW)) bus ();

    instr_issue #(.FIFO_DEPTH(DEPTH), .HAZ_WIN(HW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        vld;
        logic        empty;
        logic        rdy;
        int          icnt;
        int          bcnt;
    } exp_t;

    typedef struct {
        int         slot;
        logic [4:0] rd;
    } wr_t;

    exp_t        exp_q [$];
    logic [31:0] mq [$];
    wr_t         wr_hist [$];
    int          slot;
    int          m_icnt;
    int          m_bcnt;
    logic        m_acc;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 11'd0};
    endfunction

    // A word must wait while any writer of one of its sources was issued
    // fewer than HW slots before the slot now being filled.
    function automatic logic model_hazard(input logic [31:0] w);
        if (w[31:26] == 6'd0) return 1'b0;
        foreach (wr_hist[i]) begin
            if ((slot - wr_hist[i].slot) < HW) begin
                if (wr_hist[i].rd == w[20:16]) return 1'b1;
                if (!w[29] && (wr_hist[i].rd == w[15:11])) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Applies the inputs that were present at the edge just taken.
    task automatic model_edge();
        exp_t        e;
        logic [31:0] out;
        logic        iss;
        out = 32'h0;
        iss = 1'b0;
        if (rst) begin
            mq.delete();
            wr_hist.delete();
            slot   = 0;
            m_icnt = 0;
            m_bcnt = 0;
            m_acc  = 1'b0;
        end else begin
            m_acc = bus.in_valid && (mq.size() < DEPTH);
            if (bus.run && (mq.size() > 0)) begin
                if (!model_hazard(mq[0])) begin
                    out = mq.pop_front();
                    iss = 1'b1;
                    if (out[31:26] != 6'd0) wr_hist.push_back('{slot, out[25:21]});
                    if (m_icnt < MAXC) m_icnt++;
                end else if (m_bcnt < MAXC) begin
                    m_bcnt++;
                end
            end
            if (m_acc) mq.push_back(bus.in_instr);
            slot++;
            while ((wr_hist.size() > 0) && ((slot - wr_hist[0].slot) >= HW)) void'(wr_hist.pop_front());
        end
        e.instr = out;
        e.vld   = iss;
        e.empty = (mq.size() == 0);
        e.rdy   = (mq.size() < DEPTH);
        e.icnt  = m_icnt;
        e.bcnt  = m_bcnt;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.run = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        do begin
            step();
            guard++;
        end while (!m_acc && guard < 100);
        cmp("push_accept_timeout", {31'd0, m_acc}, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: every falling edge with a pending expectation is one DUT presentation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("instr_out",   bus.instr_out, e.instr);
                cmp("issue_valid", {31'd0, bus.issue_valid}, {31'd0, e.vld});
                cmp("empty",       {31'd0, bus.empty}, {31'd0, e.empty});
                cmp("in_ready",    {31'd0, bus.in_ready}, {31'd0, e.rdy});
                cmp("issue_cnt",   32'(bus.issue_cnt), 32'(e.icnt));
                cmp("bubble_cnt",  32'(bus.bubble_cnt), 32'(e.bcnt));
            end
        end
    end

    initial begin
        int          vcnt;
        int          first;
        int          second;
        logic [31:0] w;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'h0;
        bus.run      = 1'b0;

        // Reset state
        do_reset();
        cmp("rst_instr_out",  bus.instr_out, 32'h0);
        cmp("rst_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
        cmp("rst_issue_cnt",  32'(bus.issue_cnt), 32'd0);
        cmp("rst_bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
        cmp("rst_empty",      {31'd0, bus.empty}, 32'd1);
        cmp("rst_in_ready",   {31'd0, bus.in_ready}, 32'd1);

        // Independent stream: four back-to-back issues
        do_reset();
        for (int i = 1; i <= 4; i++) push_word(mk(6'b000010, 5'(i), 5'd10, 5'd11));
        bus.run = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.issue_valid) vcnt++;
        end
        cmp("indep_valid_cycles", 32'(vcnt), 32'd4);
        cmp("indep_issue_cnt", 32'(bus.issue_cnt), 32'd4);
        cmp("indep_bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
        bus.run = 1'b0;

        // RAW on rt: two bubbles between producer and consumer
        do_reset();
        push_word(mk(6'b000010, 5'd1, 5'd2, 5'd3));
        push_word(mk(6'b000010, 5'd4, 5'd5, 5'd1));
        bus.run = 1'b1;
        first = -1;
        second = -1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.issue_valid) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        cmp("raw_issue_gap", 32'(second - first), 32'd3);
        cmp("raw_bubble_cnt", 32'(bus.bubble_cnt), 32'd2);
        cmp("raw_issue_cnt", 32'(bus.issue_cnt), 32'd2);
        bus.run = 1'b0;

        // Immediate form: [15:11] matching rd is not a hazard
        do_reset();
        push_word(mk(6'b000010, 5'd1, 5'd2, 5'd3));
        push_word({6'b001010, 5'd5, 5'd2, 16'h0800});
        bus.run = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (bus.issue_valid) vcnt++;
        end
        cmp("imm_valid_cycles", 32'(vcnt), 32'd2);
        cmp("imm_bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
        bus.run = 1'b0;

        // Full FIFO: 17th push held until a pop has been registered
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_instr = mk(6'b000010, 5'd1, 5'd10, 5'd11);
        for (int i = 0; i < DEPTH; i++) step();
        cmp("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        cmp("full_held_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.run = 1'b1;
        step();
        cmp("full_pop_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        cmp("full_17th_accept", {31'd0, m_acc}, 32'd1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        cmp("full_issue_cnt", 32'(bus.issue_cnt), 32'd17);
        bus.run = 1'b0;

        // Reset mid-stream: buffered words and scoreboard entry discarded
        do_reset();
        push_word(mk(6'b000010, 5'd7, 5'd10, 5'd11));
        for (int i = 0; i < 5; i++) push_word(mk(6'b000010, 5'd1, 5'd10, 5'd11));
        bus.run = 1'b1;
        step();
        bus.run = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmp("midrst_instr_out", bus.instr_out, 32'h0);
        cmp("midrst_empty", {31'd0, bus.empty}, 32'd1);
        w = mk(6'b000010, 5'd8, 5'd7, 5'd7);
        push_word(w);
        bus.run = 1'b1;
        step();
        cmp("midrst_dep_valid", {31'd0, bus.issue_valid}, 32'd1);
        cmp("midrst_dep_instr", bus.instr_out, w);
        cmp("midrst_bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
        bus.run = 1'b0;

        // Random traffic; small register set provokes hazards, counters saturate
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic [5:0] op;
            case ($urandom_range(0, 3))
                0:       op = 6'd0;
                1:       op = 6'b000010;
                2:       op = 6'b001010;
                default: op = 6'($urandom);
            endcase
            rst          = ($urandom_range(0, 599) == 0);
            bus.in_valid = ($urandom_range(0, 9) < 6);
            bus.run      = ($urandom_range(0, 9) < 8);
            bus.in_instr = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3)), 11'($urandom)};
            step();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.run = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
